// File: rtl/mult_seq_param_if.sv
`default_nettype none
// ============================================================================
// mult_seq_param_if
// Operand/handshake/result bundle for the sequential shift-add multiplier.
// Revision: 1.0
// ============================================================================
interface mult_seq_param_if #(
    parameter int WIDTH = 4
);
    logic                 start_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 busy_o;
    logic                 done_o;
    logic [1:0]           state_o;
    logic [2*WIDTH-1:0]   y_o;

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, state_o, y_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, state_o, y_o
    );
endinterface
`default_nettype wire

// File: rtl/mult_seq_param.sv
`default_nettype none
// ============================================================================
// mult_seq_param
// Parametrised shift-add multiplier with start/busy/done handshake and early
// termination. Define MULT_SIGNED_EN for two's complement operands.
// Revision: 1.0
// ============================================================================
module mult_seq_param #(
    parameter int WIDTH = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    mult_seq_param_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2,
        S_RSVD = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PW-1:0]    r_a;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_y;
    logic [PW-1:0]    w_acc_sum;
    logic [PW-1:0]    w_result;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [CW-1:0]    r_cnt;
    logic             w_last;

`ifdef MULT_SIGNED_EN
    logic r_neg;

    // Magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
    assign w_a_in   = bus.a_i[WIDTH-1] ? -bus.a_i : bus.a_i;
    assign w_b_in   = bus.b_i[WIDTH-1] ? -bus.b_i : bus.b_i;
    assign w_result = r_neg ? -w_acc_sum : w_acc_sum;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_neg <= 1'b0;
        end else if (r_state == S_IDLE && bus.start_i) begin
            r_neg <= bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1];
        end
    end
`else
    assign w_a_in   = bus.a_i;
    assign w_b_in   = bus.b_i;
    assign w_result = w_acc_sum;
`endif

    assign w_acc_sum = r_b[0] ? (r_acc + r_a) : r_acc;
    // Stop as soon as no set multiplier bits remain after this step.
    assign w_last    = (r_b[WIDTH-1:1] == '0) || (r_cnt == C_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = S_IDLE;
        bus.busy_o  = 1'b0;
        bus.done_o  = 1'b0;
        bus.state_o = r_state;
        case (r_state)
            S_IDLE: w_next = bus.start_i ? S_CALC : S_IDLE;
            S_CALC: begin
                w_next     = w_last ? S_DONE : S_CALC;
                bus.busy_o = 1'b1;
            end
            S_DONE: begin
                w_next     = S_IDLE;
                bus.busy_o = 1'b1;
                bus.done_o = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_a   <= {{WIDTH{1'b0}}, w_a_in};
                        r_b   <= w_b_in;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_sum;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_y <= w_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.y_o = r_y;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_param.sv
`default_nettype none
// ============================================================================
// tb_mult_seq_param
// Random and directed stimulus on WIDTH=4 and WIDTH=8 instances against an
// arithmetic reference model. Honours MULT_SIGNED_EN.
// Revision: 1.0
// ============================================================================
module tb_mult_seq_param;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_seq_param_if #(.WIDTH(4)) b4 ();
    mult_seq_param_if #(.WIDTH(8)) b8 ();

    mult_seq_param #(.WIDTH(4)) dut4 (.clk_i(clk), .rst_i(rst_n), .bus(b4.slave));
    mult_seq_param #(.WIDTH(8)) dut8 (.clk_i(clk), .rst_i(rst_n), .bus(b8.slave));

    // Model: st (0 idle / 1 calc / 2 done), rem = CALC cycles left, prod = pending result
    typedef struct {
        int     st;
        int     rem;
        longint y;
        longint prod;
    } mdl_t;

    mdl_t m4, m8;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef MULT_SIGNED_EN
    function automatic longint sx(input longint v, input int w);
        if (v[w-1]) return v - (longint'(1) << w);
        return v;
    endfunction
    function automatic longint mag(input longint v, input int w);
        longint s = sx(v, w);
        return (s < 0) ? -s : s;
    endfunction
    function automatic longint prod(input longint a, input longint b, input int w);
        return (sx(a, w) * sx(b, w)) & ((longint'(1) << (2 * w)) - 1);
    endfunction
    localparam logic [63:0] E_1515 = 64'h01,   E_95 = 64'hDD, E_FF = 64'h0001, E_1128 = 64'hFF80;
    localparam int          L_1515 = 2,       L_FF = 2;
`else
    function automatic longint mag(input longint v, input int w);
        return v & ((longint'(1) << w) - 1);
    endfunction
    function automatic longint prod(input longint a, input longint b, input int w);
        return (a * b) & ((longint'(1) << (2 * w)) - 1);
    endfunction
    localparam logic [63:0] E_1515 = 64'hE1,   E_95 = 64'd45, E_FF = 64'hFE01, E_1128 = 64'd128;
    localparam int          L_1515 = 5,       L_FF = 9;
`endif

    function automatic int calc_cycles(input longint b, input int w);
        longint bm = mag(b, w);
        int     n  = 1;
        for (int i = 0; i < w; i++) if (bm[i]) n = i + 1;
        return n;
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit start, input longint a,
                                  input longint b, input int w);
        mdl_t r = m;
        case (m.st)
            0: if (start) begin
                r.st   = 1;
                r.rem  = calc_cycles(b, w);
                r.prod = prod(a, b, w);
            end
            1: begin
                r.rem = m.rem - 1;
                if (r.rem == 0) begin
                    r.st = 2;
                    r.y  = m.prod;
                end
            end
            default: r.st = 0;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("state4", 64'(b4.state_o), 64'(m4.st));
        chk("busy4",  64'(b4.busy_o),  64'(m4.st != 0));
        chk("done4",  64'(b4.done_o),  64'(m4.st == 2));
        chk("y4",     64'(b4.y_o),     64'(m4.y));
        chk("state8", 64'(b8.state_o), 64'(m8.st));
        chk("busy8",  64'(b8.busy_o),  64'(m8.st != 0));
        chk("done8",  64'(b8.done_o),  64'(m8.st == 2));
        chk("y8",     64'(b8.y_o),     64'(m8.y));
    endtask

    task automatic model_reset();
        m4 = '{st: 0, rem: 0, y: 0, prod: 0};
        m8 = '{st: 0, rem: 0, y: 0, prod: 0};
    endtask

    // One clock: advance the model on the rising edge, check on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m4 = step(m4, b4.start_i, longint'(b4.a_i), longint'(b4.b_i), 4);
            m8 = step(m8, b8.start_i, longint'(b8.a_i), longint'(b8.b_i), 8);
        end
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input int lane, input bit st, input logic [7:0] a, input logic [7:0] b);
        if (lane == 4) begin
            b4.start_i = st; b4.a_i = a[3:0]; b4.b_i = b[3:0];
        end else begin
            b8.start_i = st; b8.a_i = a;      b8.b_i = b;
        end
    endtask

    task automatic issue(input int lane, input logic [7:0] a, input logic [7:0] b,
                         input bit noisy, output int lat, output int busy_n);
        bit calc;
        lat    = -1;
        busy_n = 0;
        drive(lane, 1'b1, a, b);
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if ((lane == 4) ? b4.busy_o : b8.busy_o) busy_n++;
            if ((lane == 4) ? b4.done_o : b8.done_o) lat = k;
            calc = (lane == 4) ? (m4.st == 1) : (m8.st == 1);
            if (noisy && calc)
                drive(lane, 1'($urandom), 8'($urandom), 8'($urandom));
            else
                drive(lane, 1'b0, 8'($urandom), 8'($urandom));
        end
    endtask

    function automatic logic [63:0] lane_y(input int lane);
        return (lane == 4) ? 64'(b4.y_o) : 64'(b8.y_o);
    endfunction

    initial begin
        int lat, bn, lane, w;
        logic [7:0] ra, rb;
        drive(4, 1'b0, 8'd0, 8'd0);
        drive(8, 1'b0, 8'd0, 8'd0);
        model_reset();
        repeat (3) tick();
        chk("rst_y4", 64'(b4.y_o), 64'd0);
        chk("rst_state4", 64'(b4.state_o), 64'd0);
        rst_n = 1'b1;
        tick();

        issue(4, 8'd15, 8'd15, 1'b0, lat, bn);
        chk("lat_15x15", 64'(lat), 64'(L_1515));
        chk("busy_15x15", 64'(bn), 64'(L_1515));
        chk("y_15x15", lane_y(4), E_1515);
        tick();

        issue(4, 8'd7, 8'd0, 1'b0, lat, bn);
        chk("lat_7x0", 64'(lat), 64'd2);
        chk("y_7x0", lane_y(4), 64'd0);
        tick();
        issue(4, 8'd3, 8'd2, 1'b0, lat, bn);
        chk("lat_3x2", 64'(lat), 64'd3);
        chk("y_3x2", lane_y(4), 64'd6);
        tick();

        // Abort during the second CALC cycle
        drive(4, 1'b1, 8'd9, 8'd5);
        tick();
        drive(4, 1'b0, 8'd0, 8'd0);
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_state4", 64'(b4.state_o), 64'd0);
        chk("abort_y4", 64'(b4.y_o), 64'd0);
        chk("abort_done4", 64'(b4.done_o), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        issue(4, 8'd9, 8'd5, 1'b0, lat, bn);
        chk("lat_9x5", 64'(lat), 64'd4);
        chk("y_9x5", lane_y(4), E_95);
        tick();

        issue(4, 8'd6, 8'd3, 1'b1, lat, bn);
        chk("lat_6x3", 64'(lat), 64'd3);
        chk("y_6x3", lane_y(4), 64'd18);
        tick();

        issue(8, 8'd255, 8'd255, 1'b0, lat, bn);
        chk("lat_ffxff", 64'(lat), 64'(L_FF));
        chk("y_ffxff", lane_y(8), E_FF);
        tick();
        issue(8, 8'd1, 8'd128, 1'b0, lat, bn);
        chk("lat_1x128", 64'(lat), 64'd9);
        chk("y_1x128", lane_y(8), E_1128);
        tick();

`ifdef MULT_SIGNED_EN
        issue(4, 8'h8, 8'h8, 1'b0, lat, bn);
        chk("y_m8xm8", lane_y(4), 64'h40);
        chk("lat_m8xm8", 64'(lat), 64'd5);
        tick();
        issue(4, 8'hD, 8'h5, 1'b0, lat, bn);
        chk("y_m3x5", lane_y(4), 64'hF1);
        tick();
        issue(4, 8'h7, 8'hF, 1'b0, lat, bn);
        chk("y_7xm1", lane_y(4), 64'hF9);
        chk("lat_7xm1", 64'(lat), 64'd2);
        tick();
`endif

        for (int i = 0; i < 60; i++) begin
            lane = ($urandom_range(0, 1) == 0) ? 4 : 8;
            w    = lane;
            ra   = 8'($urandom_range(0, (1 << w) - 1));
            rb   = 8'($urandom_range(0, (1 << w) - 1));
            if (i % 7 == 0) rb = 8'd0;
            issue(lane, ra, rb, 1'b1, lat, bn);
            chk("lat_rand", 64'(lat), 64'(calc_cycles(longint'(rb), w) + 1));
            chk("y_rand", lane_y(lane), 64'(prod(longint'(ra), longint'(rb), w)));
            tick();
        end

        // Start held high: each new request is taken in the IDLE cycle after DONE
        for (int i = 0; i < 40; i++) begin
            drive(4, 1'b1, 8'($urandom), 8'($urandom));
            drive(8, 1'b1, 8'($urandom), 8'($urandom));
            tick();
        end
        drive(4, 1'b0, 8'd0, 8'd0);
        drive(8, 1'b0, 8'd0, 8'd0);
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
